btn_step_ctrl: RTL and testbench

Input conditioner that sits directly upstream of the core. It produces the core's `aresetn` and single-cycle `step` strobe from the board reset and push buttons, and it also gives the IO side debounced button levels and edge pulses. It supports two modes: manual single-step from a button, and free-running auto-step at a fixed period.

---
 rtl/btn_step_ctrl.sv | 108 ++++++++++
 tb/tb_btn_step_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/btn_step_ctrl.sv
// rtl/btn_step_ctrl.sv - button conditioner: synchronizers, debouncers, core reset stretcher and step strobe
// Produces the core reset and step strobe plus debounced button levels and rising-edge pulses.
module btn_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_PERIOD      = 50000000,
  parameter int RST_HOLD        = 16,
  parameter int STEP_BTN        = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] button,
  input  logic       run_mode,
  output logic       aresetn,
  output logic       step,
  output logic [4:0] btn_clean,
  output logic [4:0] btn_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RW = (RUN_PERIOD > 1) ? $clog2(RUN_PERIOD) : 1;
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CW-1:0] DB_MAX   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(RUN_PERIOD - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD - 1);

  logic [4:0]    btn_s1, btn_s2;
  logic          run_s1, run_s2;
  logic [CW-1:0] db_cnt [5];
  logic [HW-1:0] hold;
  logic [RW-1:0] run_cnt;
  logic [4:0]    accept, rise;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      run_s1 <= 1'b0;
      run_s2 <= 1'b0;
    end else begin
      btn_s1 <= button;
      btn_s2 <= btn_s1;
      run_s1 <= run_mode;
      run_s2 <= run_s1;
    end
  end

  // A debouncer accepts once its synced level has differed for DEBOUNCE_CYCLES edges in a row.
  always_comb begin
    accept = '0;
    for (int i = 0; i < 5; i++) begin
      accept[i] = (btn_s2[i] != btn_clean[i]) && (db_cnt[i] == DB_MAX);
    end
    rise = accept & btn_s2;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btn_clean <= '0;
      btn_pulse <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      btn_pulse <= rise;
      for (int i = 0; i < 5; i++) begin
        if (btn_s2[i] == btn_clean[i]) begin
          db_cnt[i] <= '0;
        end else if (accept[i]) begin
          btn_clean[i] <= btn_s2[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // The hold counter freezes at HOLD_MAX once the core is released.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold    <= '0;
      aresetn <= 1'b0;
    end else if (!aresetn) begin
      if (hold == HOLD_MAX) aresetn <= 1'b1;
      else                  hold    <= hold + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step    <= 1'b0;
      run_cnt <= '0;
    end else if (!aresetn) begin
      step    <= 1'b0;
      run_cnt <= '0;
    end else if (run_s2) begin
      if (run_cnt == RUN_MAX) begin
        step    <= 1'b1;
        run_cnt <= '0;
      end else begin
        step    <= 1'b0;
        run_cnt <= run_cnt + 1'b1;
      end
    end else begin
      run_cnt <= '0;
      step    <= rise[STEP_BTN];
    end
  end

endmodule

// File: tb/tb_btn_step_ctrl.sv
// tb/tb_btn_step_ctrl.sv - self-checking bench for btn_step_ctrl against an edge-history reference model
module tb_btn_step_ctrl;

  localparam int DB  = 4;
  localparam int RP  = 5;
  localparam int RH  = 3;
  localparam int SB  = 0;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] button;
  logic       run_mode;
  logic       aresetn;
  logic       step;
  logic [4:0] btn_clean;
  logic [4:0] btn_pulse;

  int checks   = 0;
  int failures = 0;

  // Model: raw samples per edge since the last reset release, and expected outputs.
  bit [4:0] hist [$];
  bit       rhist [$];
  int       n_edges;
  int       streak;
  bit [4:0] m_clean, m_pulse;
  bit       m_step, m_ares;

  btn_step_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .RUN_PERIOD     (RP),
    .RST_HOLD       (RH),
    .STEP_BTN       (SB)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .button   (button),
    .run_mode (run_mode),
    .aresetn  (aresetn),
    .step     (step),
    .btn_clean(btn_clean),
    .btn_pulse(btn_pulse)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    hist.delete();
    rhist.delete();
    n_edges = 0;
    streak  = 0;
    m_clean = '0;
    m_pulse = '0;
    m_step  = 1'b0;
    m_ares  = 1'b0;
  endtask

  // Synced value used at edge k is the raw value sampled two edges earlier (hist index k-3).
  task automatic model_edge(input bit [4:0] b, input bit r);
    bit       ares_before;
    bit       rs2;
    bit       v;
    bit       flip;
    bit [4:0] new_clean;
    int       k;
    n_edges++;
    hist.push_back(b);
    rhist.push_back(r);
    ares_before = m_ares;
    new_clean   = m_clean;
    m_pulse     = '0;
    for (int i = 0; i < 5; i++) begin
      flip = 1'b1;
      for (int j = 0; j < DB; j++) begin
        k = n_edges - j;
        v = (k >= 3) ? hist[k-3][i] : 1'b0;
        if (v == m_clean[i]) flip = 1'b0;
      end
      if (flip) begin
        new_clean[i] = ~m_clean[i];
        m_pulse[i]   = ~m_clean[i];
      end
    end
    m_clean = new_clean;
    rs2     = (n_edges >= 3) ? rhist[n_edges-3] : 1'b0;
    streak  = (ares_before && rs2) ? streak + 1 : 0;
    if (!ares_before)  m_step = 1'b0;
    else if (rs2)      m_step = (streak > 0) && (streak % RP == 0);
    else               m_step = m_pulse[SB];
    m_ares = (n_edges >= RH);
  endtask

  task automatic check(input string tag);
    checks++;
    assert (aresetn === m_ares) else begin
      failures++;
      $error("FAIL %s aresetn got=%0b exp=%0b", tag, aresetn, m_ares);
    end
    checks++;
    assert (step === m_step) else begin
      failures++;
      $error("FAIL %s step got=%0b exp=%0b", tag, step, m_step);
    end
    checks++;
    assert (btn_clean === m_clean) else begin
      failures++;
      $error("FAIL %s btn_clean got=%05b exp=%05b", tag, btn_clean, m_clean);
    end
    checks++;
    assert (btn_pulse === m_pulse) else begin
      failures++;
      $error("FAIL %s btn_pulse got=%05b exp=%05b", tag, btn_pulse, m_pulse);
    end
  endtask

  // Called at a falling edge; inputs are already set for the coming rising edge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (resetn) model_edge(button, run_mode);
    #1;
    check(tag);
    @(negedge clk);
  endtask

  task automatic do_reset(input int cyc, input string tag);
    resetn = 1'b0;
    #1;
    model_reset();
    check(tag);
    repeat (cyc) begin
      @(negedge clk);
      check(tag);
    end
    resetn = 1'b1;
  endtask

  initial begin
    resetn   = 1'b0;
    button   = '0;
    run_mode = 1'b0;
    model_reset();
    @(negedge clk);

    do_reset(5, "reset_hold");
    repeat (2) tick("release_early");
    do_reset(2, "reset_midcount");
    repeat (5) tick("release");

    button = 5'b00100;
    repeat (10) tick("clean_press");
    button = '0;
    repeat (10) tick("clean_release");

    for (int t = 0; t < 4; t++) begin
      button[0] = (t % 2 == 0);
      repeat (2) tick("bounce");
    end
    button[0] = 1'b1;
    repeat (100) tick("hold_step_btn");
    button = '0;
    repeat (10) tick("step_release");

    run_mode = 1'b1;
    repeat (20) tick("run_auto");
    button[0] = 1'b1;
    repeat (8) tick("run_press");
    button = '0;
    repeat (6) tick("run_unpress");
    run_mode = 1'b0;
    repeat (6) tick("run_exit");
    run_mode = 1'b1;
    repeat (14) tick("run_reenter");
    do_reset(1, "reset_in_run");
    repeat (12) tick("run_after_reset");

    for (int s = 0; s < 300; s++) begin
      button   = 5'($urandom);
      run_mode = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 60) == 0) do_reset($urandom_range(0, 2), "rand_reset");
      repeat ($urandom_range(1, 7)) tick("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
